// File: rtl/demux4_pkg.sv
// Shared constants and types for the registered 1-to-4 demultiplexer.
package demux4_pkg;
   localparam int NCH           = 4;
   localparam int DEFAULT_WIDTH = 4;

   typedef logic [1:0] ch_idx_t;

   localparam ch_idx_t CH_A = 2'd0;
   localparam ch_idx_t CH_B = 2'd1;
   localparam ch_idx_t CH_C = 2'd2;
   localparam ch_idx_t CH_D = 2'd3;
endpackage

// File: rtl/demux4_slot.sv
// One output channel: one-deep holding register with full flag, fill/drain
// handshake and same-cycle pass-through.
module demux4_slot
   import demux4_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fill,
   input  logic [WIDTH-1:0] din,
   input  logic             out_ready,
   output logic [WIDTH-1:0] dout,
   output logic             out_valid
);
   logic             full_q, full_d;
   logic [WIDTH-1:0] data_q, data_d;

   // A fill wins over a drain, so fill+drain keeps the slot full with new data.
   always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (fill) begin
         full_d = 1'b1;
         data_d = din;
      end else if (full_q && out_ready) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end

   assign dout      = data_q;
   assign out_valid = full_q;
endmodule

// File: rtl/demux4_buf.sv
// Registered 1-to-4 demultiplexer with per-channel valid/ready buffering.
// Define DEMUX_RR_EN to steer by an internal round-robin pointer instead of {S1,S0}.
module demux4_buf
   import demux4_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             S1,
   input  logic             S0,
   input  logic [WIDTH-1:0] X,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] C,
   output logic [WIDTH-1:0] D,
   output logic             a_valid,
   output logic             b_valid,
   output logic             c_valid,
   output logic             d_valid,
   input  logic             a_ready,
   input  logic             b_ready,
   input  logic             c_ready,
   input  logic             d_ready
);
   ch_idx_t          sel;
   logic [NCH-1:0]   ready_vec;
   logic [NCH-1:0]   full_vec;
   logic [NCH-1:0]   fill_vec;
   logic [WIDTH-1:0] data_arr [NCH];
   logic             accept;

`ifdef DEMUX_RR_EN
   ch_idx_t ptr_q, ptr_d;
   logic    unused_sel;

   assign unused_sel = S1 ^ S0;
   assign sel        = ptr_q;

   always_comb begin
      ptr_d = ptr_q;
      if (accept) begin
         ptr_d = ptr_q + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= CH_A;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   assign sel = {S1, S0};
`endif

   assign ready_vec = {d_ready, c_ready, b_ready, a_ready};

   // A full slot still accepts when its consumer drains in the same cycle.
   assign in_ready = ~full_vec[sel] | ready_vec[sel];
   assign accept   = in_valid & in_ready;

   for (genvar gi = 0; gi < NCH; gi++) begin : g_slot
      assign fill_vec[gi] = accept && (sel == ch_idx_t'(gi));

      demux4_slot #(
         .WIDTH(WIDTH)
      ) u_slot (
         .clk      (clk),
         .rst      (rst),
         .fill     (fill_vec[gi]),
         .din      (X),
         .out_ready(ready_vec[gi]),
         .dout     (data_arr[gi]),
         .out_valid(full_vec[gi])
      );
   end

   assign A       = data_arr[CH_A];
   assign B       = data_arr[CH_B];
   assign C       = data_arr[CH_C];
   assign D       = data_arr[CH_D];
   assign a_valid = full_vec[CH_A];
   assign b_valid = full_vec[CH_B];
   assign c_valid = full_vec[CH_C];
   assign d_valid = full_vec[CH_D];
endmodule

// File: tb/tb_demux4_buf.sv
// Self-checking bench for demux4_buf: directed scenarios plus randomized traffic
// against a queue-free behavioural model of the four holding registers.
module tb_demux4_buf;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         S1, S0;
   logic [W-1:0] X;
   logic         in_valid;
   logic [3:0]   rdy;
   logic         in_ready;
   logic [W-1:0] A, B, C, D;
   logic         a_valid, b_valid, c_valid, d_valid;

   logic [W-1:0] dout [4];
   logic [3:0]   vld;

   logic [W-1:0] data_m [4];
   bit   [3:0]   full_m;
   logic [1:0]   ptr_m;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   demux4_buf #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .S1      (S1),
      .S0      (S0),
      .X       (X),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .A       (A),
      .B       (B),
      .C       (C),
      .D       (D),
      .a_valid (a_valid),
      .b_valid (b_valid),
      .c_valid (c_valid),
      .d_valid (d_valid),
      .a_ready (rdy[0]),
      .b_ready (rdy[1]),
      .c_ready (rdy[2]),
      .d_ready (rdy[3])
   );

   assign dout[0] = A;
   assign dout[1] = B;
   assign dout[2] = C;
   assign dout[3] = D;
   assign vld     = {d_valid, c_valid, b_valid, a_valid};

   function automatic logic [1:0] cur_sel();
`ifdef DEMUX_RR_EN
      return ptr_m;
`else
      return {S1, S0};
`endif
   endfunction

   function automatic logic model_in_ready();
      logic [1:0] k;
      k = cur_sel();
      return !full_m[k] || rdy[k];
   endfunction

   // Reference behaviour at one rising edge, from the current bench inputs.
   task automatic model_step();
      logic [1:0] k;
      logic       acc;
      if (rst) begin
         for (int j = 0; j < 4; j++) begin
            full_m[j] = 1'b0;
            data_m[j] = '0;
         end
         ptr_m = 2'd0;
         return;
      end
      k   = cur_sel();
      acc = in_valid && (!full_m[k] || rdy[k]);
      for (int j = 0; j < 4; j++) begin
         if (acc && j == int'(k)) begin
            data_m[j] = X;
            full_m[j] = 1'b1;
         end else if (full_m[j] && rdy[j]) begin
            full_m[j] = 1'b0;
         end
      end
      if (acc) begin
         $display("xfer ch=%0d data=%0h", k, X);
         ptr_m = ptr_m + 2'd1;
      end
   endtask

   task automatic drive(input logic [1:0] sel, input logic [W-1:0] xv,
                        input logic iv, input logic [3:0] rv);
      @(negedge clk);
      {S1, S0} = sel;
      X        = xv;
      in_valid = iv;
      rdy      = rv;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(2'd0, 4'h0, 1'b0, 4'h0);
      tick();
      tick();
      for (int j = 0; j < 4; j++) begin
         n_cmp++;
         if (vld[j] !== 1'b0 || dout[j] !== '0) begin
            n_fail++;
            $display("FAIL reset_ch%0d: valid=%b data=%0h required valid=0 data=0", j, vld[j], dout[j]);
         end
      end
      rst = 1'b0;
      for (int s = 0; s < 4; s++) begin
         drive(2'(s), 4'h0, 1'b0, 4'h0);
         n_cmp++;
         if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready_sel%0d: got %b required 1", s, in_ready);
         end
      end
   endtask

`ifndef DEMUX_RR_EN
   task automatic test_steer();
      logic [W-1:0] exp_d [4];
      logic [3:0]   exp_v;
      exp_d = '{4'h0, 4'h0, 4'hA, 4'h0};
      exp_v = 4'b0100;
      drive(2'b10, 4'hA, 1'b1, 4'b0000);
      tick();
      for (int j = 0; j < 4; j++) begin
         n_cmp++;
         if (dout[j] !== exp_d[j] || vld[j] !== exp_v[j]) begin
            n_fail++;
            $display("FAIL steer_ch%0d: data=%0h valid=%b required data=%0h valid=%b",
                     j, dout[j], vld[j], exp_d[j], exp_v[j]);
         end
      end
   endtask

   task automatic test_backpressure();
      drive(2'b10, 4'h5, 1'b1, 4'b0000);
      n_cmp++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_stall_ready: got %b required 0", in_ready);
      end
      tick();
      n_cmp++;
      if (C !== 4'hA || c_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_hold: C=%0h c_valid=%b required C=a c_valid=1", C, c_valid);
      end
      drive(2'b10, 4'h5, 1'b1, 4'b0100);
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_release_ready: got %b required 1", in_ready);
      end
      tick();
      n_cmp++;
      if (C !== 4'h5 || c_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_passthru: C=%0h c_valid=%b required C=5 c_valid=1", C, c_valid);
      end
   endtask

   task automatic test_independent();
      drive(2'b00, 4'h7, 1'b1, 4'b0000);
      tick();
      n_cmp++;
      if (A !== 4'h7 || a_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL indep_fill_a: A=%0h a_valid=%b required A=7 a_valid=1", A, a_valid);
      end
      drive(2'b01, 4'h3, 1'b1, 4'b0001);
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL indep_ready: got %b required 1", in_ready);
      end
      tick();
      n_cmp++;
      if (B !== 4'h3 || b_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL indep_b: B=%0h b_valid=%b required B=3 b_valid=1", B, b_valid);
      end
      n_cmp++;
      if (a_valid !== 1'b0 || A !== 4'h7) begin
         n_fail++;
         $display("FAIL indep_drain_a: A=%0h a_valid=%b required A=7 a_valid=0", A, a_valid);
      end
      n_cmp++;
      if (C !== 4'h5 || c_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL indep_c_stalled: C=%0h c_valid=%b required C=5 c_valid=1", C, c_valid);
      end
   endtask

   task automatic test_select_change();
      drive(2'b10, 4'h9, 1'b1, 4'b0000);
      n_cmp++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL selchg_stall: got %b required 0", in_ready);
      end
      tick();
      drive(2'b11, 4'h9, 1'b1, 4'b0000);
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL selchg_ready: got %b required 1", in_ready);
      end
      tick();
      n_cmp++;
      if (D !== 4'h9 || d_valid !== 1'b1 || C !== 4'h5) begin
         n_fail++;
         $display("FAIL selchg_d: D=%0h d_valid=%b C=%0h required D=9 d_valid=1 C=5", D, d_valid, C);
      end
      drive(2'b11, 4'h9, 1'b0, 4'b1000);
      tick();
      n_cmp++;
      if (d_valid !== 1'b0 || D !== 4'h9) begin
         n_fail++;
         $display("FAIL selchg_once: D=%0h d_valid=%b required D=9 d_valid=0", D, d_valid);
      end
   endtask
`else
   task automatic test_round_robin();
      rst = 1'b1;
      drive(2'd0, 4'h0, 1'b0, 4'hF);
      tick();
      rst = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         drive(2'd0, 4'(i), 1'b1, 4'hF);
         tick();
         n_cmp++;
         if (dout[(i-1)%4] !== 4'(i) || vld[(i-1)%4] !== 1'b1) begin
            n_fail++;
            $display("FAIL rr_word%0d: ch%0d data=%0h valid=%b required data=%0h valid=1",
                     i, (i-1)%4, dout[(i-1)%4], vld[(i-1)%4], 4'(i));
         end
      end
   endtask
`endif

   task automatic test_random();
      logic exp_rdy;
      for (int n = 0; n < 300; n++) begin
         drive(2'($urandom_range(0, 3)), 4'($urandom), 1'($urandom_range(0, 3) != 0),
               {1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0),
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0)});
         exp_rdy = model_in_ready();
         n_cmp++;
         if (in_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL rand_in_ready@%0d: got %b required %b", n, in_ready, exp_rdy);
         end
         tick();
         for (int j = 0; j < 4; j++) begin
            n_cmp++;
            if (dout[j] !== data_m[j] || vld[j] !== full_m[j]) begin
               n_fail++;
               $display("FAIL rand_ch%0d@%0d: data=%0h valid=%b required data=%0h valid=%b",
                        j, n, dout[j], vld[j], data_m[j], full_m[j]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      drive(2'd0, 4'h0, 1'b0, 4'hF);
      tick();
      for (int s = 0; s < 4; s++) begin
         drive(2'(s), 4'(s + 1), 1'b1, 4'h0);
         tick();
      end
      n_cmp++;
      if (vld !== 4'hF) begin
         n_fail++;
         $display("FAIL rstmid_filled: valid=%b required 1111", vld);
      end
      rst = 1'b1;
      drive(2'd1, 4'hF, 1'b1, 4'h0);
      tick();
      for (int j = 0; j < 4; j++) begin
         n_cmp++;
         if (vld[j] !== 1'b0 || dout[j] !== '0) begin
            n_fail++;
            $display("FAIL rstmid_ch%0d: data=%0h valid=%b required data=0 valid=0", j, dout[j], vld[j]);
         end
      end
      rst = 1'b0;
      drive(2'd0, 4'hE, 1'b1, 4'h0);
      tick();
      n_cmp++;
      if (A !== 4'hE || vld !== 4'b0001) begin
         n_fail++;
         $display("FAIL rstmid_ptr: A=%0h valid=%b required A=e valid=0001", A, vld);
      end
   endtask

   initial begin
      rst      = 1'b1;
      S1       = 1'b0;
      S0       = 1'b0;
      X        = '0;
      in_valid = 1'b0;
      rdy      = 4'h0;
      full_m   = '0;
      ptr_m    = 2'd0;
      for (int j = 0; j < 4; j++) data_m[j] = '0;

      test_reset();
`ifndef DEMUX_RR_EN
      test_steer();
      test_backpressure();
      test_independent();
      test_select_change();
`else
      test_round_robin();
`endif
      test_random();
      test_reset_mid();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/demux4_buf.md
# demux4_buf

Registered 1-to-4 demultiplexer with per-channel valid/ready handshake: the distributing end of the 4:1 bus multiplexer used elsewhere in the design. One input word stream, steered by select `S1`,`S0`, is delivered to one of four output channels `A`, `B`, `C` or `D`. Each channel has a one-deep holding register, so a stalled consumer back-pressures only writes aimed at its own channel.

## Interface
Parameters:
- `WIDTH`, default 4: data width of the input word and of each output channel.

Ports:
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst`: input, 1 bit. Reset, synchronous and active-high.
- `S1`, `S0`: input, 1 bit each. Channel select, `{S1,S0}`: 00→A, 01→B, 10→C, 11→D. Ignored when `DEMUX_RR_EN` is defined.
- `X`: input, `WIDTH` bits. Input data word.
- `in_valid`: input, 1 bit. `X` holds a word.
- `in_ready`: output, 1 bit. The selected channel can take a word this cycle.
- `A`, `B`, `C`, `D`: output, `WIDTH` bits each. Channel data, registered.
- `a_valid`, `b_valid`, `c_valid`, `d_valid`: output, 1 bit each. Channel holds a word.
- `a_ready`, `b_ready`, `c_ready`, `d_ready`: input, 1 bit each. Consumer takes the word.

## Operation
- Selected channel `k` is given by `{S1,S0}`, or by the internal round-robin pointer when `DEMUX_RR_EN` is defined.
- Each channel has a `full` flag and a data register.
- `in_ready = ~full[k] | ready[k]`. It is combinational from the current select, `full[k]` and `ready[k]`.
- An input word is accepted when `in_valid & in_ready` at a clock edge. On acceptance, `X` is written into channel `k` and `full[k]` is set to 1.
- An output word is drained when `valid[j] & ready[j]` at a clock edge. On drain, `full[j]` is cleared to 0, unless channel `j` accepts a new word in the same cycle.
- Simultaneous drain and fill on the same channel is a pass-through. The new word replaces the old one, `valid` stays 1, and there is no bubble.
- Drains on non-selected channels proceed independently, all in parallel.
- `valid[j] = full[j]`.
- When a channel is empty, its data output holds its last value. It is not cleared.
- The select may change while `in_valid` is held during a stall. `in_ready` follows the new select immediately. No word is duplicated or lost, because acceptance only happens at a handshake edge.
- No state machine beyond the four `full` flags and the optional pointer.

## Timing
- Reset values: `A`/`B`/`C`/`D` = 0; all `*_valid` = 0; round-robin pointer = 0. After reset, `in_ready` = 1 for every select.
- `rst` overrides everything. Any word in flight is discarded, and a handshake in the reset cycle has no effect.
- Latency is 1 cycle. A word accepted at edge *n* appears on its channel with valid = 1 after edge *n*.
- Throughput is 1 word/cycle when the target consumer holds ready = 1.
- A full channel whose consumer holds ready = 0 forces `in_ready` = 0 while selected. The data then stays stable until drained.

## Configuration
- `DEMUX_RR_EN` defined:
  - `S1`/`S0` are ignored.
  - A 2-bit pointer selects the channel.
  - The pointer advances by 1 on each accepted word and wraps 3→0.
  - The pointer holds when no word is accepted.
- `DEMUX_RR_EN` undefined: the pointer logic is absent and the select comes from `{S1,S0}` only.

## Structure
- Package `demux4_pkg`:
  - constant `NCH` = 4;
  - typedef `ch_idx_t` (2 bits);
  - default `WIDTH` constant;
  - encoding constants `CH_A`…`CH_D` = 0…3.
- Sub-module `demux4_slot`: one channel holding register with `full` flag, fill/drain handshake and pass-through. It is instantiated four times.
- The top level contains the select decode, the `in_ready` mux and the optional pointer.

## Test plan
- Reset then steer: reset, then `{S1,S0}`=10, `X`=0xA, `in_valid`=1 for one cycle with `c_ready`=0. Required: after the edge, `C`=0xA and `c_valid`=1; `a_valid`, `b_valid`, `d_valid` = 0; `A`/`B`/`D` = 0.
- Backpressure: with C full and `c_ready`=0, present `X`=0x5 to select 10. Required: `in_ready`=0 and `C` stays 0xA. Then raise `c_ready`=1. Required: `in_ready`=1, and after the edge `C`=0x5 with `c_valid`=1 (pass-through).
- Independent channels: C full and stalled, select 01, `X`=0x3. Required: `in_ready`=1 and after the edge `B`=0x3 with `b_valid`=1. A drain on A in the same cycle clears `a_valid`.
- Select change mid-stall: hold `in_valid` with select 10 (C stalled), then switch to 11. Required: `in_ready` rises in the same cycle and `D` receives the word exactly once.
- Round-robin (`DEMUX_RR_EN`): accept words 1,2,3,4,5 back-to-back with all ready = 1. Required: the words land on A,B,C,D,A with values 1,2,3,4,5, and the pointer wraps to 1.
- Reset mid-operation: fill all four channels, then assert `rst` with `in_valid`=1. Required: after the edge all valid = 0, all data = 0, pointer = 0, and the word is not captured.
